// File: rtl/algo_mawr_ingress_queue.sv
// Multi-agent write ingress queue: merges up to NUMMAPT agent writes per cycle into a
// shared FIFO and drains one entry per cycle onto the core's single write port.
module algo_mawr_ingress_queue #(
  parameter int NUMMAPT  = 4,
  parameter int WIDTH    = 32,
  parameter int BITADDR  = 13,
  parameter int DEPTH    = 16,
  parameter int BITDEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       ready_i,
  input  logic [NUMMAPT-1:0]         ma_write_i,
  input  logic [NUMMAPT*BITADDR-1:0] ma_adr_i,
  input  logic [NUMMAPT*WIDTH-1:0]   ma_din_i,
  output logic [NUMMAPT-1:0]         ma_bp_o,
  input  logic [7:0]                 bp_thr_i,
  input  logic                       wr_stall_i,
  output logic                       write_o,
  output logic [BITADDR-1:0]         wr_adr_o,
  output logic [WIDTH-1:0]           din_o,
  output logic [BITDEPTH:0]          count_o,
  output logic                       ovfl_o
);

  localparam logic [BITDEPTH:0] FULL   = (BITDEPTH+1)'(DEPTH);
  localparam logic [BITDEPTH:0] BP_LIM = (BITDEPTH+1)'(DEPTH - NUMMAPT);
  localparam logic [BITDEPTH:0] ONE    = (BITDEPTH+1)'(1);

  logic [BITADDR-1:0]  adr_mem_q [DEPTH];
  logic [WIDTH-1:0]    din_mem_q [DEPTH];
  logic [BITDEPTH-1:0] wptr_q, wptr_d;
  logic [BITDEPTH-1:0] rptr_q, rptr_d;
  logic [BITDEPTH:0]   count_q, count_d;
  logic                write_q;
  logic [BITADDR-1:0]  wr_adr_q;
  logic [WIDTH-1:0]    din_q;
  logic                ovfl_q, ovfl_d;
  logic                bp_q, bp_d;

  logic                deq;
  logic                drop;
  logic [BITDEPTH:0]   free_slots;
  logic [BITDEPTH:0]   nacc;
  logic [7:0]          count_ext;
  logic [NUMMAPT-1:0]  acc;
  logic [BITDEPTH-1:0] slot [NUMMAPT];

  always_comb begin
    deq        = ready_i & ~wr_stall_i & (count_q != '0);
    // a pop in the same cycle frees its slot for this cycle's enqueues
    free_slots = FULL - count_q + {{BITDEPTH{1'b0}}, deq};
    nacc       = '0;
    drop       = 1'b0;
    acc        = '0;
    for (int i = 0; i < NUMMAPT; i++) begin
      slot[i] = wptr_q + nacc[BITDEPTH-1:0];
      if (ma_write_i[i]) begin
        if (nacc < free_slots) begin
          acc[i] = 1'b1;
          nacc   = nacc + ONE;
        end else begin
          drop = 1'b1;
        end
      end
    end
    count_d   = count_q - {{BITDEPTH{1'b0}}, deq} + nacc;
    wptr_d    = wptr_q + nacc[BITDEPTH-1:0];
    rptr_d    = rptr_q + {{(BITDEPTH-1){1'b0}}, deq};
    ovfl_d    = ovfl_q | drop;
    count_ext = {{(7-BITDEPTH){1'b0}}, count_d};
    bp_d      = ~ready_i | (count_ext >= bp_thr_i) | (count_d > BP_LIM);
  end

  // storage is not reset; pointers and count decide what is valid
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUMMAPT; i++) begin
      if (acc[i]) begin
        adr_mem_q[slot[i]] <= ma_adr_i[i*BITADDR +: BITADDR];
        din_mem_q[slot[i]] <= ma_din_i[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      write_q  <= 1'b0;
      wr_adr_q <= '0;
      din_q    <= '0;
      ovfl_q   <= 1'b0;
      bp_q     <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      write_q <= deq;
      ovfl_q  <= ovfl_d;
      bp_q    <= bp_d;
      if (deq) begin
        wr_adr_q <= adr_mem_q[rptr_q];
        din_q    <= din_mem_q[rptr_q];
      end
    end
  end

  assign ma_bp_o  = {NUMMAPT{bp_q}};
  assign write_o  = write_q;
  assign wr_adr_o = wr_adr_q;
  assign din_o    = din_q;
  assign count_o  = count_q;
  assign ovfl_o   = ovfl_q;

endmodule

// File: tb/tb_algo_mawr_ingress_queue.sv
// Scoreboard bench for algo_mawr_ingress_queue: a queue-based reference model predicts
// every registered output; a negedge monitor pops expected writes and compares.
module tb_algo_mawr_ingress_queue;

  localparam int NA = 4;
  localparam int W  = 32;
  localparam int BA = 13;
  localparam int DP = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ready = 1'b0;
  logic [NA-1:0]     ma_write = '0;
  logic [NA*BA-1:0]  ma_adr = '0;
  logic [NA*W-1:0]   ma_din = '0;
  logic [NA-1:0]     ma_bp;
  logic [7:0]        bp_thr = 8'd12;
  logic              wr_stall = 1'b0;
  logic              write;
  logic [BA-1:0]     wr_adr;
  logic [W-1:0]      din;
  logic [4:0]        count;
  logic              ovfl;

  algo_mawr_ingress_queue dut (
    .clk_i(clk), .rst_i(rst), .ready_i(ready), .ma_write_i(ma_write),
    .ma_adr_i(ma_adr), .ma_din_i(ma_din), .ma_bp_o(ma_bp), .bp_thr_i(bp_thr),
    .wr_stall_i(wr_stall), .write_o(write), .wr_adr_o(wr_adr), .din_o(din),
    .count_o(count), .ovfl_o(ovfl)
  );

  always #5 clk = ~clk;

  // reference model state: FIFO contents as {adr, din}
  logic [BA+W-1:0] mq [$];
  logic [BA+W-1:0] sbq [$];
  logic            exp_write = 1'b0;
  logic [BA-1:0]   exp_adr = '0;
  logic [W-1:0]    exp_din = '0;
  int              exp_cnt = 0;
  logic            exp_ovfl = 1'b0;
  logic [NA-1:0]   exp_bp = '1;
  logic            chk_en = 1'b0;

  logic [BA-1:0]   adr_v [NA];
  logic [W-1:0]    din_v [NA];

  int n_vec = 0;
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic [BA+W-1:0] e;
      check("write", 64'(write), 64'(exp_write));
      if (write === 1'b1) begin
        if (sbq.size() == 0) begin
          check("unexpected_write", 64'(1), 64'(0));
        end else begin
          e = sbq.pop_front();
          check("sb_adr", 64'(wr_adr), 64'(e[BA+W-1:W]));
          check("sb_din", 64'(din), 64'(e[W-1:0]));
        end
      end
      check("wr_adr_hold", 64'(wr_adr), 64'(exp_adr));
      check("din_hold", 64'(din), 64'(exp_din));
      check("count", 64'(count), 64'(exp_cnt));
      check("ovfl", 64'(ovfl), 64'(exp_ovfl));
      check("ma_bp", 64'(ma_bp), 64'(exp_bp));
    end
  end

  // apply one cycle of stimulus, advance the model, return after the checking negedge
  task automatic step(input logic r, input logic rdy, input logic stl, input logic [NA-1:0] wr);
    logic [BA+W-1:0] e;
    rst = r; ready = rdy; wr_stall = stl; ma_write = wr;
    for (int i = 0; i < NA; i++) begin
      ma_adr[i*BA +: BA] = adr_v[i];
      ma_din[i*W +: W]   = din_v[i];
    end
    if (r) begin
      mq.delete();
      exp_write = 1'b0; exp_adr = '0; exp_din = '0;
      exp_ovfl = 1'b0; exp_bp = '1;
    end else begin
      if (rdy && !stl && mq.size() != 0) begin
        e = mq.pop_front();
        sbq.push_back(e);
        exp_write = 1'b1;
        exp_adr = e[BA+W-1:W];
        exp_din = e[W-1:0];
      end else begin
        exp_write = 1'b0;
      end
      for (int i = 0; i < NA; i++) begin
        if (wr[i]) begin
          if (mq.size() < DP) mq.push_back({adr_v[i], din_v[i]});
          else exp_ovfl = 1'b1;
        end
      end
      exp_bp = {NA{(!rdy) || (mq.size() >= int'(bp_thr)) || (mq.size() > DP - NA)}};
    end
    exp_cnt = mq.size();
    chk_en = 1'b1;
    n_vec++;
    @(negedge clk);
    #2;
  endtask

  task automatic rand_data();
    for (int i = 0; i < NA; i++) begin
      adr_v[i] = BA'($urandom);
      din_v[i] = $urandom;
    end
  endtask

  task automatic idle(input int n, input logic rdy, input logic stl);
    for (int k = 0; k < n; k++) begin
      rand_data();
      step(1'b0, rdy, stl, '0);
    end
  endtask

  initial begin
    rand_data();
    step(1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, '0);
    idle(8, 1'b1, 1'b0);

    // single agent write, minimum latency
    rand_data();
    adr_v[2] = 13'h0123; din_v[2] = 32'hDEADBEEF;
    step(1'b0, 1'b1, 1'b0, 4'b0100);
    idle(3, 1'b1, 1'b0);

    // all agents in one cycle drain in index order
    for (int i = 0; i < NA; i++) begin
      adr_v[i] = BA'(16 + i); din_v[i] = $urandom;
    end
    step(1'b0, 1'b1, 1'b0, 4'b1111);
    idle(6, 1'b1, 1'b0);

    // threshold backpressure under stall
    bp_thr = 8'd8;
    rand_data(); step(1'b0, 1'b1, 1'b1, 4'b1111);
    rand_data(); step(1'b0, 1'b1, 1'b1, 4'b1111);
    idle(2, 1'b1, 1'b1);
    idle(10, 1'b1, 1'b0);
    bp_thr = 8'd12;

    // overflow: 20 writes into 16 slots
    for (int k = 0; k < 5; k++) begin
      rand_data(); step(1'b0, 1'b1, 1'b1, 4'b1111);
    end
    idle(2, 1'b1, 1'b1);
    // full FIFO with simultaneous dequeue admits exactly one
    rand_data(); step(1'b0, 1'b1, 1'b0, 4'b1111);
    idle(20, 1'b1, 1'b0);

    // reset mid-operation
    rand_data(); step(1'b0, 1'b1, 1'b1, 4'b1111);
    rand_data(); step(1'b0, 1'b1, 1'b1, 4'b0001);
    rand_data(); step(1'b1, 1'b1, 1'b1, '0);
    idle(4, 1'b1, 1'b0);

    // ready low holds the queue and forces backpressure
    rand_data(); step(1'b0, 1'b0, 1'b0, 4'b1011);
    idle(3, 1'b0, 1'b0);
    idle(5, 1'b1, 1'b0);

    // bp_thr = 0 keeps backpressure asserted
    bp_thr = 8'd0;
    idle(3, 1'b1, 1'b0);

    // randomized traffic: first ignoring backpressure, then honoring it
    for (int k = 0; k < 3000; k++) begin
      logic [NA-1:0] wr;
      logic honor;
      honor = (k >= 1500);
      if ($urandom_range(0, 49) == 0) bp_thr = 8'($urandom_range(0, 18));
      rand_data();
      wr = NA'($urandom);
      if (honor && exp_bp[0]) wr = '0;
      if (honor && exp_ovfl && $urandom_range(0, 9) == 0)
        step(1'b1, 1'b1, 1'b0, '0);
      else
        step(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) != 0),
             ($urandom_range(0, 3) == 0), wr);
    end
    idle(24, 1'b1, 1'b0);

    check("sb_drained", 64'(sbq.size()), 64'(0));
    check("model_drained", 64'(mq.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
